// File: rtl/delay_tap_scheduler.sv
// Time-multiplexes one single-port stereo sample RAM between the sample writer and
// NUM_TAPS delay taps: one write per sample strobe, then one read per tap.
module delay_tap_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_TAPS   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_strobe,
  input  logic [DATA_WIDTH-1:0]            audio_left_in,
  input  logic [DATA_WIDTH-1:0]            audio_right_in,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0]   tap_delay,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic                             ram_we,
  output logic [2*DATA_WIDTH-1:0]          ram_wdata,
  input  logic [2*DATA_WIDTH-1:0]          ram_rdata,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]   tap_left_out,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]   tap_right_out,
  output logic                             tap_valid,
  output logic                             busy,
  output logic                             overrun
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned KW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   last_ptr;
  logic [KW-1:0]   tap_idx;
  logic [AW-1:0]   delay_q     [NUM_TAPS];
  logic [DW-1:0]   shadow_left [NUM_TAPS];
  logic [DW-1:0]   shadow_right[NUM_TAPS];

  // Saturate a requested delay at the oldest sample the RAM still holds.
  function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] d);
    logic [AW:0] wide;
    wide = {1'b0, d};
    clamp_delay = (wide > (AW+1)'(DEPTH - 1)) ? AW'(DEPTH - 1) : d;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      last_ptr      <= '0;
      tap_idx       <= '0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      tap_left_out  <= '0;
      tap_right_out <= '0;
      tap_valid     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        delay_q[k]      <= '0;
        shadow_left[k]  <= '0;
        shadow_right[k] <= '0;
      end
    end else begin
      tap_valid <= 1'b0;
      // Any strobe while a schedule is running is dropped and flagged.
      if (sample_strobe && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            for (int k = 0; k < int'(NUM_TAPS); k++) begin
              delay_q[k] <= clamp_delay(tap_delay[k*AW +: AW]);
            end
            ram_we    <= 1'b1;
            ram_addr  <= wr_ptr;
            ram_wdata <= {audio_left_in, audio_right_in};
            busy      <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          ram_we   <= 1'b0;
          last_ptr <= wr_ptr;
          wr_ptr   <= wr_ptr + 1'b1;
          ram_addr <= wr_ptr - delay_q[0];
          tap_idx  <= '0;
          state    <= READ;
        end
        READ: begin
          // Read data lags the address by one cycle, so tap k-1 lands now.
          if (tap_idx != '0) begin
            shadow_left[KW'(tap_idx - 1'b1)]  <= ram_rdata[2*DW-1:DW];
            shadow_right[KW'(tap_idx - 1'b1)] <= ram_rdata[DW-1:0];
          end
          if (tap_idx == KW'(NUM_TAPS - 1)) begin
            state <= CAPTURE;
          end else begin
            tap_idx  <= tap_idx + 1'b1;
            ram_addr <= last_ptr - delay_q[KW'(tap_idx + 1'b1)];
          end
        end
        CAPTURE: begin
          // Last tap comes straight from the RAM; all taps update together.
          for (int k = 0; k < int'(NUM_TAPS); k++) begin
            if (k == int'(NUM_TAPS) - 1) begin
              tap_left_out[k*DW +: DW]  <= ram_rdata[2*DW-1:DW];
              tap_right_out[k*DW +: DW] <= ram_rdata[DW-1:0];
            end else begin
              tap_left_out[k*DW +: DW]  <= shadow_left[k];
              tap_right_out[k*DW +: DW] <= shadow_right[k];
            end
          end
          tap_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Directed bench for delay_tap_scheduler with a behavioural 1-cycle-latency stereo RAM.
module tb_delay_tap_scheduler;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sample_strobe = 1'b0;
  logic [DW-1:0]   audio_left_in = '0;
  logic [DW-1:0]   audio_right_in = '0;
  logic [N*AW-1:0] tap_delay = '0;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [2*DW-1:0] ram_wdata;
  logic [2*DW-1:0] ram_rdata = '0;
  logic [N*DW-1:0] tap_left_out;
  logic [N*DW-1:0] tap_right_out;
  logic            tap_valid;
  logic            busy;
  logic            overrun;

  logic [2*DW-1:0] mem [16];

  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;
  int n_valid = 0;

  delay_tap_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(N)) dut (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
    .audio_left_in(audio_left_in), .audio_right_in(audio_right_in),
    .tap_delay(tap_delay), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tap_left_out(tap_left_out), .tap_right_out(tap_right_out),
    .tap_valid(tap_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (ram_we) n_writes <= n_writes + 1;
    if (tap_valid) n_valid <= n_valid + 1;
  end

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  waddr;
    logic [31:0] t0;
    logic [31:0] t1;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tap0();
    return {tap_left_out[15:0], tap_right_out[15:0]};
  endfunction

  function automatic logic [31:0] tap1();
    return {tap_left_out[31:16], tap_right_out[31:16]};
  endfunction

  task automatic set_in(input logic [15:0] l, input logic [15:0] r,
                        input logic [3:0] d0, input logic [3:0] d1);
    audio_left_in  = l;
    audio_right_in = r;
    tap_delay      = {d1, d0};
  endtask

  // Strobe at E0, then sample the write cycle and the tap_valid cycle after E4.
  task automatic strobe_and_wait(input logic [15:0] l, input logic [15:0] r,
                                 input logic [3:0] d0, input logic [3:0] d1,
                                 output logic [4:0] wr_info, output logic valid_seen);
    set_in(l, r, d0, d1);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    wr_info = {ram_we, ram_addr};
    idle(4);
    valid_seen = tap_valid;
  endtask

  initial begin
    logic [4:0] wi;
    logic       vs;
    int         snap_w;
    int         snap_v;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    tbl[0] = '{16'h1111, 16'h2222, 4'd0,  4'd0, 4'd0, 32'h11112222, 32'h11112222};
    tbl[1] = '{16'h0AAA, 16'h0BBB, 4'd1,  4'd0, 4'd1, 32'h11112222, 32'h0AAA0BBB};
    tbl[2] = '{16'h8000, 16'h7FFF, 4'd2,  4'd1, 4'd2, 32'h11112222, 32'h0AAA0BBB};
    tbl[3] = '{16'hFFFF, 16'h0001, 4'd0,  4'd3, 4'd3, 32'hFFFF0001, 32'h11112222};
    tbl[4] = '{16'h1234, 16'h5678, 4'd5,  4'd2, 4'd4, 32'h00000000, 32'h80007FFF};
    tbl[5] = '{16'hCAFE, 16'hBEEF, 4'd15, 4'd4, 4'd5, 32'h00000000, 32'h0AAA0BBB};

    idle(2);
    reset = 1'b0;
    check("reset_ram_we",   64'(ram_we), 64'd0);
    check("reset_ram_addr", 64'(ram_addr), 64'd0);
    check("reset_wdata",    64'(ram_wdata), 64'd0);
    check("reset_taps",     {tap_left_out, tap_right_out}, 64'd0);
    check("reset_flags",    64'({tap_valid, busy, overrun}), 64'd0);

    // Table vectors from reset: write addresses 0..5, reads hit earlier table samples.
    for (int v = 0; v < 6; v++) begin
      strobe_and_wait(tbl[v].l, tbl[v].r, tbl[v].d0, tbl[v].d1, wi, vs);
      check($sformatf("vec%0d_write", v), 64'(wi), 64'({1'b1, tbl[v].waddr}));
      check($sformatf("vec%0d_valid", v), 64'(vs), 64'd1);
      check($sformatf("vec%0d_tap0", v), 64'(tap0()), 64'(tbl[v].t0));
      check($sformatf("vec%0d_tap1", v), 64'(tap1()), 64'(tbl[v].t1));
      tick();
      check($sformatf("vec%0d_idle", v), 64'({tap_valid, busy}), 64'd0);
      idle(2);
    end

    // Stream of 20 samples with delays {3,15}; write pointer wraps 15 -> 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    snap_w = n_writes;
    snap_v = n_valid;
    for (int i = 0; i < 20; i++) begin
      strobe_and_wait(16'(i), 16'(16'h0100 + i), 4'd3, 4'd15, wi, vs);
      if (i == 15) check("stream_waddr15", 64'(wi), 64'h1F);
      if (i == 16) check("stream_waddr16_wrap", 64'(wi), 64'h10);
      idle(3);
    end
    check("stream_tap0", 64'(tap0()), 64'h00100110);
    check("stream_tap1", 64'(tap1()), 64'h00040104);
    check("stream_writes", 64'(n_writes - snap_w), 64'd20);
    check("stream_valids", 64'(n_valid - snap_v), 64'd20);
    check("stream_no_overrun", 64'(overrun), 64'd0);

    // Maximum delay 15 from wr_ptr 4: both reads address (4-15) mod 16 = 5.
    set_in(16'h3333, 16'h3434, 4'd15, 4'd15);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    check("maxdly_read_addr", 64'({ram_we, ram_addr}), 64'h05);
    idle(3);
    check("maxdly_tap0", 64'(tap0()), 64'h00050105);
    check("maxdly_tap1", 64'(tap1()), 64'h00050105);
    idle(3);

    // Strobe two cycles into a schedule: dropped, overrun sticks.
    snap_w = n_writes;
    set_in(16'h4444, 16'h4545, 4'd0, 4'd1);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    set_in(16'hDEAD, 16'hBEEF, 4'd0, 4'd0);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("ovr_flag", 64'({overrun, busy}), 64'h3);
    idle(2);
    check("ovr_valid", 64'(tap_valid), 64'd1);
    check("ovr_tap0", 64'(tap0()), 64'h44444545);
    check("ovr_tap1", 64'(tap1()), 64'h33333434);
    check("ovr_one_write", 64'(n_writes - snap_w), 64'd1);
    idle(3);
    strobe_and_wait(16'h5555, 16'h5656, 4'd1, 4'd0, wi, vs);
    check("ovr_next_write", 64'(wi), 64'h16);
    check("ovr_next_taps", {tap0(), tap1()}, 64'h4444454555555656);
    check("ovr_sticky", 64'(overrun), 64'd1);
    idle(3);

    // Delay change mid-schedule is ignored until the next strobe.
    set_in(16'h6666, 16'h6767, 4'd0, 4'd0);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    tap_delay = {4'd2, 4'd2};
    idle(3);
    check("dlychg_taps", {tap0(), tap1()}, 64'h6666676766666767);
    idle(3);
    strobe_and_wait(16'h7777, 16'h7878, 4'd2, 4'd2, wi, vs);
    check("dlychg_next_taps", {tap0(), tap1()}, 64'h5555565655555656);
    idle(3);

    // Reset at E2 aborts the schedule; the committed write survives.
    snap_v = n_valid;
    set_in(16'h9999, 16'h9A9A, 4'd0, 4'd0);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_outputs", {tap_left_out, tap_right_out}, 64'd0);
    check("abort_flags", 64'({tap_valid, busy, overrun, ram_we, ram_addr}), 64'd0);
    idle(6);
    check("abort_no_valid", 64'(n_valid - snap_v), 64'd0);
    strobe_and_wait(16'hAAAA, 16'hABAB, 4'd7, 4'd0, wi, vs);
    check("abort_wrptr0", 64'(wi), 64'h10);
    check("abort_kept_write", {tap0(), tap1()}, 64'h99999A9AAAAAABAB);
    idle(3);

    // Reset and strobe together: reset wins.
    snap_w = n_writes;
    reset = 1'b1;
    sample_strobe = 1'b1;
    tick();
    reset = 1'b0;
    sample_strobe = 1'b0;
    idle(5);
    check("rst_strobe_no_write", 64'(n_writes - snap_w), 64'd0);
    check("rst_strobe_flags", 64'({busy, overrun}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
